// File: rtl/decoder_pkg.sv
// Shared sizing for the 8-line event encoder: line count, code width, pointer reset.
// Pure constants and types; no state, no latency, no flow control.
// Imported by event_encoder_8_3 and prio_sel_8.
package decoder_pkg;

  localparam int N_LINES = 8;
  localparam int IDX_W   = 3;

  localparam logic [IDX_W-1:0] PTR_RST = 3'd7;

  typedef logic [N_LINES-1:0] lines_t;
  typedef logic [IDX_W-1:0]   idx_t;

  function automatic lines_t onehot(input idx_t idx);
    return lines_t'(1) << idx;
  endfunction

endpackage

// File: rtl/prio_sel_8.sv
// Picks one pending line: highest index, or rotating from pointer+1 with EVENT_ENCODER_ROUND_ROBIN_EN.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is consumed.
module prio_sel_8
  import decoder_pkg::*;
(
  input  logic [N_LINES-1:0] pending,
  input  logic [IDX_W-1:0]   pointer,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
  // Walk offsets 8 down to 1 so the smallest offset after the pointer wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N_LINES; i >= 1; i--) begin
      if (pending[pointer + IDX_W'(i)]) begin
        idx   = pointer + IDX_W'(i);
        found = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^pointer;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_LINES; i++) begin
      if (pending[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/event_encoder_8_3.sv
// Latches 8 event lines into a pending vector and presents one code at a time (EVENT_ENCODER_ROUND_ROBIN_EN selects rotation).
// Latency: event -> Pend one edge, Pend -> Out/V one further edge.
// Backpressure: Out/V hold while V=1 and Rdy=0; events keep accumulating, repeats set sticky Ovf.
module event_encoder_8_3
  import decoder_pkg::*;
(
  input  logic                Clk,
  input  logic                Rst,
  input  logic                E,
  input  logic [N_LINES-1:0]  In,
  output logic [IDX_W-1:0]    Out,
  output logic                V,
  input  logic                Rdy,
  output logic [N_LINES-1:0]  Pend,
  output logic                Ovf
);

  lines_t p;
  lines_t cap;
  lines_t clr;
  idx_t   sel_idx;
  idx_t   sel_ptr;
  logic   found;
  logic   free;
  logic   load;

  assign free = !V || Rdy;
  assign load = free && found;
  assign cap  = E ? In : '0;
  assign clr  = load ? onehot(sel_idx) : '0;
  assign Pend = p;

  prio_sel_8 u_sel (
    .pending (p),
    .pointer (sel_ptr),
    .idx     (sel_idx),
    .found   (found)
  );

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
  idx_t ptr;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ptr <= PTR_RST;
    end else if (load) begin
      ptr <= sel_idx;
    end
  end

  assign sel_ptr = ptr;
`else
  assign sel_ptr = PTR_RST;
`endif

  // A new event on the line being cleared this edge survives (set wins).
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      p   <= '0;
      Out <= '0;
      V   <= 1'b0;
      Ovf <= 1'b0;
    end else begin
      p <= (p & ~clr) | cap;
      if (free) begin
        V <= found;
        if (found) begin
          Out <= sel_idx;
        end
      end
      if (|(cap & p & ~clr)) begin
        Ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_event_encoder_8_3.sv
// Directed and random stimulus for event_encoder_8_3 against an integer reference model.
module tb_event_encoder_8_3;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       E   = 1'b0;
  logic [7:0] In  = 8'h00;
  logic       Rdy = 1'b0;
  logic [2:0] Out;
  logic       V;
  logic [7:0] Pend;
  logic       Ovf;

  int tests = 0;
  int fails = 0;

  // reference model state
  bit [7:0] mp;
  int       mout;
  bit       mv;
  bit       movf;
  int       mptr;

  event_encoder_8_3 dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .E    (E),
    .In   (In),
    .Out  (Out),
    .V    (V),
    .Rdy  (Rdy),
    .Pend (Pend),
    .Ovf  (Ovf)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mp   = 8'h00;
    mout = 0;
    mv   = 1'b0;
    movf = 1'b0;
    mptr = 7;
  endtask

  task automatic model_edge(input logic e, input logic [7:0] din, input logic rdy);
    int cl;
    int k;
    cl = -1;
    k  = -1;
    if (!mv || rdy) begin
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
      for (int d = 1; d <= 8; d++)
        if (k < 0 && mp[(mptr + d) % 8]) k = (mptr + d) % 8;
`else
      for (int d = 7; d >= 0; d--)
        if (k < 0 && mp[d]) k = d;
`endif
      if (k >= 0) begin
        mout = k;
        mv   = 1'b1;
        cl   = k;
        mptr = k;
      end else begin
        mv = 1'b0;
      end
    end
    for (int j = 0; j < 8; j++)
      if (e && din[j] && mp[j] && j != cl) movf = 1'b1;
    for (int j = 0; j < 8; j++)
      mp[j] = (mp[j] && j != cl) || (e && din[j]);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out"},  {5'd0, Out},  8'(mout));
    chk({tag, ".v"},    {7'd0, V},    {7'd0, mv});
    chk({tag, ".pend"}, Pend,         mp);
    chk({tag, ".ovf"},  {7'd0, Ovf},  {7'd0, movf});
  endtask

  // Drive inputs, advance one edge, then compare just after it.
  task automatic cyc(input string tag, input logic e, input logic [7:0] din, input logic rdy);
    E   = e;
    In  = din;
    Rdy = rdy;
    @(posedge Clk);
    model_edge(e, din, rdy);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    check_all("post_reset");

    // single event
    cyc("single0", 1'b1, 8'h10, 1'b1);
    cyc("single1", 1'b0, 8'h00, 1'b1);
`ifndef EVENT_ENCODER_ROUND_ROBIN_EN
    chk("single_code", {5'd0, Out}, 8'd4);
`endif
    chk("single_v", {7'd0, V}, 8'd1);
    cyc("single2", 1'b0, 8'h00, 1'b1);
    chk("single_vdrop", {7'd0, V}, 8'd0);
    chk("single_pend", Pend, 8'h00);

    // several lines in one cycle
    cyc("prio0", 1'b1, 8'h85, 1'b1);
    cyc("prio1", 1'b0, 8'h00, 1'b1);
`ifndef EVENT_ENCODER_ROUND_ROBIN_EN
    chk("prio_code7", {5'd0, Out}, 8'd7);
`endif
    cyc("prio2", 1'b0, 8'h00, 1'b1);
`ifndef EVENT_ENCODER_ROUND_ROBIN_EN
    chk("prio_code2", {5'd0, Out}, 8'd2);
`endif
    cyc("prio3", 1'b0, 8'h00, 1'b1);
`ifndef EVENT_ENCODER_ROUND_ROBIN_EN
    chk("prio_code0", {5'd0, Out}, 8'd0);
`endif
    chk("prio_ovf", {7'd0, Ovf}, 8'd0);
    cyc("prio4", 1'b0, 8'h00, 1'b1);

    // backpressure holds the presented code
    cyc("bp0", 1'b1, 8'h03, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc("bp_hold", 1'b0, 8'h00, 1'b0);
`ifndef EVENT_ENCODER_ROUND_ROBIN_EN
      chk("bp_hold_code", {5'd0, Out}, 8'd1);
`endif
      chk("bp_hold_v", {7'd0, V}, 8'd1);
    end
    cyc("bp_rel0", 1'b0, 8'h00, 1'b1);
`ifndef EVENT_ENCODER_ROUND_ROBIN_EN
    chk("bp_code0", {5'd0, Out}, 8'd0);
`endif
    cyc("bp_rel1", 1'b0, 8'h00, 1'b1);
    chk("bp_drained", {7'd0, V}, 8'd0);

    // set wins on the clearing edge, then overflow on a held line
    cyc("sw0", 1'b1, 8'h08, 1'b0);
    cyc("sw1", 1'b1, 8'h08, 1'b0);
    chk("sw_code", {5'd0, Out}, 8'd3);
    chk("sw_pend", Pend, 8'h08);
    chk("sw_ovf", {7'd0, Ovf}, 8'd0);
    cyc("ovf0", 1'b1, 8'h08, 1'b0);
    chk("ovf_set", {7'd0, Ovf}, 8'd1);
    cyc("sw2", 1'b0, 8'h00, 1'b1);
    chk("sw_again", {5'd0, Out}, 8'd3);
    chk("sw_again_v", {7'd0, V}, 8'd1);
    cyc("sw3", 1'b0, 8'h00, 1'b1);

    // asynchronous reset while a code is presented
    cyc("mr0", 1'b1, 8'h1C, 1'b0);
    cyc("mr1", 1'b0, 8'h00, 1'b0);
`ifndef EVENT_ENCODER_ROUND_ROBIN_EN
    chk("mr_pend_pre", Pend, 8'h0C);
`endif
    chk("mr_v_pre", {7'd0, V}, 8'd1);
    Rst = 1'b1;
    #2;
    model_reset();
    check_all("mid_reset");
    Rst = 1'b0;

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
    cyc("rr_fill", 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cyc("rr", 1'b1, 8'hFF, 1'b1);
      chk("rr_code", {5'd0, Out}, 8'(i % 8));
    end
    Rst = 1'b1;
    #2;
    model_reset();
    check_all("rr_reset");
    Rst = 1'b0;
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic       e;
      logic [7:0] d;
      logic       r;
      e = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7));
      r = ($urandom_range(0, 2) != 0);
      cyc("rand", e, d, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
